// File: rtl/riscv_chk_pkg.sv
// rtl/riscv_chk_pkg.sv - shared types for the checkpoint checker
package riscv_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } chk_state_t;

    typedef enum logic [2:0] {
        FC_NONE       = 3'd0,
        FC_MISMATCH   = 3'd1,
        FC_MISSED     = 3'd2,
        FC_INCOMPLETE = 3'd3,
        FC_TIMEOUT    = 3'd4
    } fail_code_t;

    typedef struct packed {
        logic [31:0] num;
        logic [31:0] ans;
    } chk_entry_t;

    localparam int ENTRY_W = $bits(chk_entry_t);

endpackage

// File: rtl/chk_table.sv
// rtl/chk_table.sv - checkpoint table, one write port and one combinational read port
module chk_table
    import riscv_chk_pkg::*;
#(
    parameter int NUM_CHK = 40,
    parameter int IDX_W   = 6
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  chk_entry_t       wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output chk_entry_t       rd_data
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHK - 1);

    chk_entry_t mem_q [NUM_CHK];

    always_ff @(posedge clk) begin
        if (wr_en && (wr_idx <= LAST_IDX)) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    // ptr may sit one past the last entry after a full run; read zeros there
    assign rd_data = (rd_idx <= LAST_IDX) ? mem_q[rd_idx] : '0;

endmodule

// File: rtl/riscv_checkpoint_checker.sv
// rtl/riscv_checkpoint_checker.sv - run monitor comparing core output against loaded checkpoints
module riscv_checkpoint_checker
    import riscv_chk_pkg::*;
#(
    parameter int          NUM_CHK = 40,
    parameter int          IDX_W   = 6,
    parameter logic [31:0] TIMEOUT = 32'd1000000
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             LD_VALID,
    input  logic [31:0]      LD_NUM_INST,
    input  logic [31:0]      LD_ANS,
    output logic             LD_READY,
    input  logic             CLR,
    input  logic             START,
    input  logic [31:0]      NUM_INST,
    input  logic [31:0]      OUTPUT_PORT,
    input  logic             HALT,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [2:0]       FAIL_CODE,
    output logic [IDX_W-1:0] FAIL_IDX,
    output logic [31:0]      FAIL_VAL,
    output logic [IDX_W-1:0] CHK_CNT,
    output logic [IDX_W-1:0] PASS_CNT,
    output logic [31:0]      CYCLE_CNT
);

    localparam logic [IDX_W-1:0] NUM_CHK_W = IDX_W'(NUM_CHK);

    chk_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d, ptr_n;
    logic [IDX_W-1:0] chk_cnt_q, chk_cnt_d;
    logic [31:0]      cycle_cnt_q, cycle_cnt_d;
    fail_code_t       fail_code_q, fail_code_d;
    logic [IDX_W-1:0] fail_idx_q, fail_idx_d;
    logic [31:0]      fail_val_q, fail_val_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             ld_ready_q, ld_ready_d;
    logic             wr_en;
    logic             start_run;
    logic             verdict;
    chk_entry_t       cur;

    chk_table #(
        .NUM_CHK (NUM_CHK),
        .IDX_W   (IDX_W)
    ) u_table (
        .clk     (CLK),
        .wr_en   (wr_en),
        .wr_idx  (chk_cnt_q),
        .wr_data ({LD_NUM_INST, LD_ANS}),
        .rd_idx  (ptr_q),
        .rd_data (cur)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        ptr_n       = ptr_q;
        chk_cnt_d   = chk_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        fail_code_d = fail_code_q;
        fail_idx_d  = fail_idx_q;
        fail_val_d  = fail_val_q;
        wr_en       = 1'b0;
        start_run   = 1'b0;
        verdict     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (CLR) begin
                    chk_cnt_d = '0;
                end else if (LD_VALID && ld_ready_q) begin
                    wr_en     = 1'b1;
                    chk_cnt_d = chk_cnt_q + 1'b1;
                end
                start_run = START && (chk_cnt_d != '0);
            end
            ST_RUN: begin
                cycle_cnt_d = cycle_cnt_q + 32'd1;
                if ((ptr_q < chk_cnt_q) && (NUM_INST == cur.num)) begin
                    if (OUTPUT_PORT == cur.ans) begin
                        ptr_n = ptr_q + 1'b1;
                    end else begin
                        verdict     = 1'b1;
                        state_d     = ST_FAIL;
                        fail_code_d = FC_MISMATCH;
                        fail_val_d  = OUTPUT_PORT;
                    end
                end else if ((ptr_q < chk_cnt_q) && (NUM_INST > cur.num)) begin
                    verdict     = 1'b1;
                    state_d     = ST_FAIL;
                    fail_code_d = FC_MISSED;
                end
                // HALT and timeout see the pointer after this cycle's match
                if (!verdict) begin
                    if (HALT) begin
                        if (ptr_n == chk_cnt_q) begin
                            state_d = ST_PASS;
                        end else begin
                            state_d     = ST_FAIL;
                            fail_code_d = FC_INCOMPLETE;
                        end
                    end else if (cycle_cnt_q == (TIMEOUT - 32'd1)) begin
                        state_d     = ST_FAIL;
                        fail_code_d = FC_TIMEOUT;
                    end
                end
                if (state_d == ST_FAIL) begin
                    fail_idx_d = ptr_n;
                end
                ptr_d = ptr_n;
            end
            default: begin
                start_run = START;
            end
        endcase

        if (start_run) begin
            state_d     = ST_RUN;
            ptr_d       = '0;
            cycle_cnt_d = '0;
            fail_code_d = FC_NONE;
            fail_idx_d  = '0;
            fail_val_d  = '0;
        end

        busy_d     = (state_d == ST_RUN);
        done_d     = (state_d == ST_PASS) || (state_d == ST_FAIL);
        pass_d     = (state_d == ST_PASS);
        ld_ready_d = (state_d == ST_IDLE) && (chk_cnt_d < NUM_CHK_W);
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            chk_cnt_q   <= '0;
            cycle_cnt_q <= '0;
            fail_code_q <= FC_NONE;
            fail_idx_q  <= '0;
            fail_val_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            ld_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            chk_cnt_q   <= chk_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            fail_code_q <= fail_code_d;
            fail_idx_q  <= fail_idx_d;
            fail_val_q  <= fail_val_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            ld_ready_q  <= ld_ready_d;
        end
    end

    assign LD_READY  = ld_ready_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign PASS      = pass_q;
    assign FAIL_CODE = fail_code_q;
    assign FAIL_IDX  = fail_idx_q;
    assign FAIL_VAL  = fail_val_q;
    assign CHK_CNT   = chk_cnt_q;
    assign PASS_CNT  = ptr_q;
    assign CYCLE_CNT = cycle_cnt_q;

endmodule

// File: tb/tb_riscv_checkpoint_checker.sv
// tb/tb_riscv_checkpoint_checker.sv - randomized and directed bench for riscv_checkpoint_checker
module tb_riscv_checkpoint_checker;

    localparam int          NUM_CHK = 40;
    localparam int          IDX_W   = 6;
    localparam int          TO      = 16;

    logic             CLK = 1'b0;
    logic             RSTn = 1'b0;
    logic             LD_VALID = 1'b0;
    logic [31:0]      LD_NUM_INST = '0;
    logic [31:0]      LD_ANS = '0;
    logic             LD_READY;
    logic             CLR = 1'b0;
    logic             START = 1'b0;
    logic [31:0]      NUM_INST = '0;
    logic [31:0]      OUTPUT_PORT = '0;
    logic             HALT = 1'b0;
    logic             BUSY, DONE, PASS;
    logic [2:0]       FAIL_CODE;
    logic [IDX_W-1:0] FAIL_IDX, CHK_CNT, PASS_CNT;
    logic [31:0]      FAIL_VAL, CYCLE_CNT;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mt_num[$];
    logic [31:0] mt_ans[$];
    logic [31:0] tr_num[$];
    logic [31:0] tr_out[$];
    bit          tr_halt[$];

    riscv_checkpoint_checker #(
        .NUM_CHK (NUM_CHK),
        .IDX_W   (IDX_W),
        .TIMEOUT (32'(TO))
    ) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .LD_VALID    (LD_VALID),
        .LD_NUM_INST (LD_NUM_INST),
        .LD_ANS      (LD_ANS),
        .LD_READY    (LD_READY),
        .CLR         (CLR),
        .START       (START),
        .NUM_INST    (NUM_INST),
        .OUTPUT_PORT (OUTPUT_PORT),
        .HALT        (HALT),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .PASS        (PASS),
        .FAIL_CODE   (FAIL_CODE),
        .FAIL_IDX    (FAIL_IDX),
        .FAIL_VAL    (FAIL_VAL),
        .CHK_CNT     (CHK_CNT),
        .PASS_CNT    (PASS_CNT),
        .CYCLE_CNT   (CYCLE_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        RSTn = 1'b0; LD_VALID = 1'b0; CLR = 1'b0; START = 1'b0; HALT = 1'b0;
        NUM_INST = '0; OUTPUT_PORT = '0;
        step; step;
        chk("rst.ld_ready", LD_READY, 1);
        chk("rst.busy", BUSY, 0);
        chk("rst.done", DONE, 0);
        chk("rst.pass", PASS, 0);
        chk("rst.fail_code", FAIL_CODE, 0);
        chk("rst.fail_idx", FAIL_IDX, 0);
        chk("rst.fail_val", FAIL_VAL, 0);
        chk("rst.chk_cnt", CHK_CNT, 0);
        chk("rst.pass_cnt", PASS_CNT, 0);
        chk("rst.cycle_cnt", CYCLE_CNT, 0);
        RSTn = 1'b1;
        mt_num.delete(); mt_ans.delete();
    endtask

    task automatic load(input logic [31:0] num, input logic [31:0] ans);
        LD_VALID = 1'b1; LD_NUM_INST = num; LD_ANS = ans;
        step;
        LD_VALID = 1'b0;
        if (mt_num.size() < NUM_CHK) begin
            mt_num.push_back(num);
            mt_ans.push_back(ans);
        end
        chk("load.chk_cnt", CHK_CNT, mt_num.size());
    endtask

    task automatic tr_add(input logic [31:0] num, input logic [31:0] out, input bit halt);
        tr_num.push_back(num); tr_out.push_back(out); tr_halt.push_back(halt);
    endtask

    task automatic tr_clear;
        tr_num.delete(); tr_out.delete(); tr_halt.delete();
    endtask

    // Reference: walk the trace against the checkpoint list, one step per RUN cycle.
    task automatic run_trace(input string tag);
        int          k, cyc, code, fidx, i, n;
        logic [31:0] fval, c_num, c_out;
        bit          done, pass, c_halt;
        n = mt_num.size();
        START = 1'b1;
        step;
        START = 1'b0;
        chk({tag, ".start_busy"}, BUSY, 1);
        chk({tag, ".start_cycle"}, CYCLE_CNT, 0);
        chk({tag, ".start_pass_cnt"}, PASS_CNT, 0);
        chk({tag, ".start_code"}, FAIL_CODE, 0);
        k = 0; cyc = 0; code = 0; fidx = 0; fval = '0; done = 0; pass = 0; i = 0;
        while (!done && i < 100) begin
            if (i < tr_num.size()) begin
                c_num = tr_num[i]; c_out = tr_out[i]; c_halt = tr_halt[i];
            end else begin
                c_num = tr_num[tr_num.size()-1]; c_out = tr_out[tr_num.size()-1]; c_halt = 1'b1;
            end
            NUM_INST = c_num; OUTPUT_PORT = c_out; HALT = c_halt;
            step;
            i++;
            cyc++;
            if (k < n && c_num == mt_num[k]) begin
                if (c_out == mt_ans[k]) k++;
                else begin done = 1; code = 1; fidx = k; fval = c_out; end
            end else if (k < n && c_num > mt_num[k]) begin
                done = 1; code = 2; fidx = k;
            end
            if (!done && c_halt) begin
                done = 1;
                if (k == n) pass = 1;
                else begin code = 3; fidx = k; end
            end else if (!done && cyc == TO) begin
                done = 1; code = 4; fidx = k;
            end
            chk({tag, ".done"}, DONE, done);
            chk({tag, ".pass_cnt"}, PASS_CNT, k);
            chk({tag, ".cycle"}, CYCLE_CNT, cyc);
        end
        HALT = 1'b0;
        chk({tag, ".busy"}, BUSY, 0);
        chk({tag, ".pass"}, PASS, pass);
        chk({tag, ".code"}, FAIL_CODE, code);
        chk({tag, ".idx"}, FAIL_IDX, fidx);
        chk({tag, ".val"}, FAIL_VAL, fval);
        NUM_INST = NUM_INST + 1; OUTPUT_PORT = $urandom; CLR = 1'b1; LD_VALID = 1'b1;
        step; step;
        CLR = 1'b0; LD_VALID = 1'b0;
        chk({tag, ".frozen_cycle"}, CYCLE_CNT, cyc);
        chk({tag, ".frozen_done"}, DONE, 1);
        chk({tag, ".frozen_chk_cnt"}, CHK_CNT, n);
    endtask

    task automatic build_t1;
        tr_clear;
        for (int v = 0; v <= 6; v++) begin
            tr_add(v, (v == 4) ? 32'h0f00 : (v == 6) ? 32'h0018 : $urandom, 1'b0);
        end
        tr_add(6, 32'h0018, 1'b1);
    endtask

    task automatic rand_run(input int it);
        logic [31:0] num, out;
        int          r;
        tr_clear;
        num = 0;
        for (int j = 0; j < 24; j++) begin
            r = $urandom_range(0, 15);
            if (j > 0) num = num + ((r < 4) ? 0 : (r == 15) ? 2 : 1);
            out = $urandom;
            foreach (mt_num[e]) begin
                if (mt_num[e] == num && $urandom_range(0, 7) != 0) out = mt_ans[e];
            end
            tr_add(num, out, $urandom_range(0, 19) == 0);
        end
        run_trace($sformatf("rnd%0d", it));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        do_reset;

        load(32'd4, 32'h0f00);
        load(32'd6, 32'h0018);
        build_t1;
        run_trace("pass");
        chk("pass.explicit_pass", PASS, 1);
        chk("pass.explicit_cnt", PASS_CNT, 2);
        chk("pass.explicit_code", FAIL_CODE, 0);

        tr_clear;
        for (int x = 0; x <= 4; x++) tr_add(x, (x == 4) ? 32'h0f01 : 32'h0, 1'b0);
        run_trace("mismatch");
        chk("mismatch.explicit_code", FAIL_CODE, 1);
        chk("mismatch.explicit_idx", FAIL_IDX, 0);
        chk("mismatch.explicit_val", FAIL_VAL, 32'h0f01);

        tr_clear;
        for (int x = 0; x < 4; x++) tr_add(x, 32'h0, 1'b0);
        for (int x = 0; x < 5; x++) tr_add(4, 32'h0f00, 1'b0);
        tr_add(5, 32'h0, 1'b1);
        run_trace("stall");
        chk("stall.explicit_cnt", PASS_CNT, 1);
        chk("stall.explicit_code", FAIL_CODE, 3);
        chk("stall.explicit_idx", FAIL_IDX, 1);

        tr_clear;
        for (int x = 0; x <= 5; x++) tr_add(x, (x == 4) ? 32'h0f00 : 32'h7, 1'b0);
        tr_add(6, 32'h0018, 1'b1);
        run_trace("halt_match");
        chk("halt_match.explicit_pass", PASS, 1);

        tr_clear;
        for (int x = 0; x <= 5; x++) tr_add(x, (x == 4) ? 32'h0f00 : 32'h7, 1'b0);
        tr_add(7, 32'h0018, 1'b0);
        run_trace("missed");
        chk("missed.explicit_code", FAIL_CODE, 2);
        chk("missed.explicit_idx", FAIL_IDX, 1);

        tr_clear;
        for (int x = 0; x < 20; x++) tr_add(0, $urandom, 1'b0);
        run_trace("timeout");
        chk("timeout.explicit_code", FAIL_CODE, 4);
        chk("timeout.explicit_cycle", CYCLE_CNT, TO);

        build_t1;
        run_trace("rerun");
        chk("rerun.explicit_pass", PASS, 1);

        do_reset;
        for (int x = 0; x < NUM_CHK + 1; x++) load(x + 1, $urandom);
        chk("full.chk_cnt", CHK_CNT, NUM_CHK);
        chk("full.ld_ready", LD_READY, 0);
        CLR = 1'b1; LD_VALID = 1'b1;
        step;
        CLR = 1'b0; LD_VALID = 1'b0;
        mt_num.delete(); mt_ans.delete();
        chk("clr.chk_cnt", CHK_CNT, 0);
        chk("clr.ld_ready", LD_READY, 1);

        load(32'd3, 32'h55);
        load(32'd9, 32'h66);
        START = 1'b1;
        step;
        START = 1'b0;
        for (int x = 0; x < 3; x++) begin NUM_INST = x; step; end
        chk("midrun.busy", BUSY, 1);
        do_reset;

        for (int it = 0; it < 12; it++) begin
            do_reset;
            v = $urandom_range(1, 3);
            for (int e = 0; e < $urandom_range(1, 4); e++) begin
                load(v, $urandom);
                v = v + $urandom_range(1, 3);
            end
            rand_run(it);
            if ($urandom_range(0, 1) == 1) rand_run(it + 100);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
